// File: rtl/usb_apb_master_if.sv
// Command/response stream plus APB3 bus bundle for usb_apb_master.
// master: the initiator's view; slave: the host/peripheral side.
interface usb_apb_master_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              busy;

    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid,
        input  cmd_write,
        input  cmd_addr,
        input  cmd_wdata,
        input  rsp_ready,
        input  prdata,
        input  pready,
        input  pslverr,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output rsp_timeout,
        output busy,
        output psel,
        output penable,
        output paddr,
        output pwrite,
        output pwdata
    );

    modport slave (
        output cmd_valid,
        output cmd_write,
        output cmd_addr,
        output cmd_wdata,
        output rsp_ready,
        output prdata,
        output pready,
        output pslverr,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  rsp_timeout,
        input  busy,
        input  psel,
        input  penable,
        input  paddr,
        input  pwrite,
        input  pwdata
    );
endinterface

// File: rtl/usb_apb_master.sv
// APB3 initiator for the USB-channel register bus: one command in,
// one APB transfer, one response out, with wait states and timeout.
module usb_apb_master #(
    parameter int ADDR_W         = 40,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic clk,
    input logic reset,
    usb_apb_master_if.master bus
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W =
        TO_EN ? (($clog2(TIMEOUT_CYCLES + 1) > 0)
                 ? $clog2(TIMEOUT_CYCLES + 1) : 1)
              : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_to_q, rsp_to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    pwdata_d  = bus.cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready wins over an abort landing in the same cycle
                if (bus.pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d   = bus.pslverr;
                    rsp_to_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_usb_apb_master.sv
// Randomised self-checking bench for usb_apb_master against a
// transaction-level model of latency, timeout and response contents.
module tb_usb_apb_master;

    localparam int AW = 40;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;

    usb_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    usb_apb_master #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level expectation from wait-state count alone.
    function automatic void model(
        input  logic          wr,
        input  int            waits,
        input  logic [DW-1:0] rd,
        input  logic          se,
        output int            rc,
        output int            acc,
        output logic [DW-1:0] xrd,
        output logic          xerr,
        output logic          xto
    );
        bit tmo;
        tmo  = (TO > 0) && (waits >= TO);
        acc  = tmo ? TO : waits + 1;
        rc   = acc + 2;
        xrd  = (tmo || wr) ? '0 : rd;
        xerr = tmo || se;
        xto  = tmo;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one command and acts as a slave inserting 'waits'
    // low-pready ACCESS cycles; records what it saw.
    task automatic do_txn(
        input  logic          wr,
        input  logic [AW-1:0] addr,
        input  logic [DW-1:0] wd,
        input  int            waits,
        input  logic [DW-1:0] rd,
        input  logic          se,
        input  int            rdelay,
        input  bit            hold,
        output int            rc,
        output int            psc,
        output int            pec,
        output bit            stable,
        output logic [DW-1:0] o_rd,
        output logic          o_err,
        output logic          o_to,
        output bit            rsp_stable,
        output bit            ok_bp,
        output bit            ok_end
    );
        int k;
        int acc;
        psc = 0; pec = 0; acc = 0;
        stable = 1; rsp_stable = 1; ok_bp = 1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        step();
        k = 1;
        while (bus.rsp_valid !== 1'b1 && k < 300) begin
            if (bus.psel === 1'b1) begin
                psc++;
                if (bus.paddr !== addr || bus.pwdata !== wd ||
                    bus.pwrite !== wr)
                    stable = 0;
            end
            if (bus.penable === 1'b1) pec++;
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = {8'($urandom), 32'($urandom)};
            bus.cmd_wdata = $urandom;
            bus.prdata    = $urandom;
            bus.pslverr   = 1'($urandom);
            bus.pready    = 1'b0;
            if (bus.penable === 1'b1) begin
                acc++;
                if (acc > waits) begin
                    bus.pready  = 1'b1;
                    bus.prdata  = rd;
                    bus.pslverr = se;
                end
            end
            step();
            k++;
        end
        rc = (bus.rsp_valid === 1'b1) ? k : -1;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        o_rd  = bus.rsp_rdata;
        o_err = bus.rsp_err;
        o_to  = bus.rsp_timeout;
        for (int i = 0; i < rdelay; i++) begin
            step();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o_rd ||
                bus.rsp_err !== o_err || bus.rsp_timeout !== o_to)
                rsp_stable = 0;
            if (bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0 ||
                bus.penable !== 1'b0)
                ok_bp = 0;
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        ok_end = (bus.rsp_valid === 1'b0 && bus.cmd_ready === 1'b1 &&
                  bus.busy === 1'b0);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 40'h12_3456_789A;
        bus.cmd_wdata = 32'hCAFE_F00D;
        bus.rsp_ready = 1'b0;
        bus.prdata    = 32'h5555_AAAA;
        bus.pready    = 1'b1;
        bus.pslverr   = 1'b1;
        step(); step(); step();
        n_tests++;
        if (bus.psel !== 0 || bus.penable !== 0 || bus.pwrite !== 0) begin
            n_fail++;
            $display("FAIL reset_bus: psel=%b penable=%b pwrite=%b want 0 0 0",
                     bus.psel, bus.penable, bus.pwrite);
        end
        n_tests++;
        if (bus.paddr !== '0 || bus.pwdata !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: paddr=%h pwdata=%h want 0 0",
                     bus.paddr, bus.pwdata);
        end
        n_tests++;
        if (bus.rsp_valid !== 0 || bus.rsp_rdata !== '0 ||
            bus.rsp_err !== 0 || bus.rsp_timeout !== 0) begin
            n_fail++;
            $display("FAIL reset_rsp: v=%b d=%h e=%b t=%b want 0 0 0 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                     bus.rsp_timeout);
        end
        n_tests++;
        if (bus.cmd_ready !== 1 || bus.busy !== 0) begin
            n_fail++;
            $display("FAIL reset_state: cmd_ready=%b busy=%b want 1 0",
                     bus.cmd_ready, bus.busy);
        end
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic check_txn(
        input string         name,
        input logic          wr,
        input int            waits,
        input logic [DW-1:0] rd,
        input logic          se,
        input int            rdelay,
        input bit            hold,
        input logic [AW-1:0] addr,
        input logic [DW-1:0] wd
    );
        int rc, psc, pec, xrc, xacc;
        bit st, rs, bp, en;
        logic [DW-1:0] ord, xrd;
        logic oerr, oto, xerr, xto;
        model(wr, waits, rd, se, xrc, xacc, xrd, xerr, xto);
        do_txn(wr, addr, wd, waits, rd, se, rdelay, hold,
               rc, psc, pec, st, ord, oerr, oto, rs, bp, en);
        n_tests++;
        if (rc !== xrc) begin
            n_fail++;
            $display("FAIL %s rsp_cycle: got %0d want %0d", name, rc, xrc);
        end
        n_tests++;
        if (psc !== xacc + 1 || pec !== xacc) begin
            n_fail++;
            $display("FAIL %s bus_cycles: psel %0d penable %0d want %0d %0d",
                     name, psc, pec, xacc + 1, xacc);
        end
        n_tests++;
        if (st !== 1'b1) begin
            n_fail++;
            $display("FAIL %s addr_stable: got %b want 1", name, st);
        end
        n_tests++;
        if (ord !== xrd || oerr !== xerr || oto !== xto) begin
            n_fail++;
            $display("FAIL %s rsp: rdata=%h err=%b to=%b want %h %b %b",
                     name, ord, oerr, oto, xrd, xerr, xto);
        end
        n_tests++;
        if (rs !== 1'b1 || bp !== 1'b1) begin
            n_fail++;
            $display("FAIL %s backpressure: stable=%b idle_bus=%b want 1 1",
                     name, rs, bp);
        end
        n_tests++;
        if (en !== 1'b1 || bus.paddr !== addr) begin
            n_fail++;
            $display("FAIL %s end: ok=%b paddr=%h want 1 %h",
                     name, en, bus.paddr, addr);
        end
    endtask

    task automatic test_write();
        check_txn("write", 1'b1, 0, 32'h0, 1'b0, 0, 1'b0,
                  40'h004, 32'hDEAD_BEEF);
    endtask

    task automatic test_wait_read();
        check_txn("wait_read", 1'b0, 3, 32'h0000_0001, 1'b0, 0, 1'b0,
                  40'h010, 32'h1357_9BDF);
    endtask

    task automatic test_slverr();
        check_txn("slverr", 1'b0, 1, 32'hA5A5_0F0F, 1'b1, 1, 1'b0,
                  40'h020, 32'h0);
    endtask

    task automatic test_timeout();
        check_txn("timeout", 1'b0, 1000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0,
                  40'h030, 32'h0);
        check_txn("abort_edge", 1'b0, TO - 1, 32'h0BAD_CAFE, 1'b0, 0,
                  1'b0, 40'h034, 32'h0);
        check_txn("timeout_wr", 1'b1, TO, 32'h0, 1'b0, 2, 1'b0,
                  40'h038, 32'h7777_0000);
    endtask

    task automatic test_backpressure();
        check_txn("bp_first", 1'b0, 0, 32'h1111_2222, 1'b0, 5, 1'b1,
                  40'h040, 32'h0);
        check_txn("bp_second", 1'b1, 2, 32'h0, 1'b0, 0, 1'b0,
                  40'h044, 32'h3333_4444);
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 40'h050;
        bus.pready    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        step(); step(); step();
        n_tests++;
        if (bus.penable !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: penable=%b want 1", bus.penable);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (bus.psel !== 0 || bus.penable !== 0 || bus.rsp_valid !== 0 ||
            bus.cmd_ready !== 1) begin
            n_fail++;
            $display("FAIL midreset: psel=%b pen=%b rv=%b crdy=%b want 0 0 0 1",
                     bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready);
        end
        bus.rsp_ready = 1'b1;
        step(); step();
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (bus.rsp_valid !== 0 || bus.busy !== 0) begin
            n_fail++;
            $display("FAIL midreset_drop: rsp_valid=%b busy=%b want 0 0",
                     bus.rsp_valid, bus.busy);
        end
        check_txn("after_reset", 1'b0, 1, 32'h600D_600D, 1'b0, 0, 1'b0,
                  40'h054, 32'h0);
    endtask

    task automatic test_back_to_back();
        int c0;
        int rc, psc, pec;
        bit st, rs, bp, en;
        logic [DW-1:0] ord;
        logic oerr, oto;
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            do_txn(1'(i), 40'(i * 4), 32'(i), 0, 32'(i + 9), 1'b0, 0,
                   1'b0, rc, psc, pec, st, ord, oerr, oto, rs, bp, en);
        n_tests++;
        if (cyc - c0 !== 16) begin
            n_fail++;
            $display("FAIL back_to_back: %0d cycles want 16", cyc - c0);
        end
    endtask

    task automatic test_random();
        logic          wr, se;
        int            waits, rdl;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        for (int i = 0; i < 40; i++) begin
            wr    = 1'($urandom);
            se    = 1'($urandom);
            waits = $urandom_range(0, TO + 4);
            rdl   = $urandom_range(0, 3);
            a     = {8'($urandom), 32'($urandom)};
            wd    = $urandom;
            rd    = $urandom;
            check_txn("random", wr, waits, rd, se, rdl, 1'b0, a, wd);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        test_reset();
        test_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
